demux_chip_1to2: RTL and testbench

- Sequential 1-to-2 stream demultiplexer; receive-side counterpart of mux_chip_2to1.
- Routes a single valid/ready input stream to channel A or channel B, one frame at a time.
- Each channel has its own 2-entry output buffer, so a stalled channel does not block the other channel once its frame ends.

---
 rtl/demux_chip_1to2.sv | 184 ++++++++++++++++++
 tb/tb_demux_chip_1to2.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/demux_chip_1to2.sv
// 1-to-2 frame demultiplexer: routes a valid/ready stream to channel A or B per frame,
// each channel behind its own 2-entry registered buffer. Optional macro: DEMUX_FRAME_COUNT_EN.

module demux_chip_1to2_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  output logic             full,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} fill_t;

  fill_t            cnt, cnt_next;
  logic [WIDTH-1:0] head_data, tail_data;
  logic             head_last, tail_last;
  logic             pop;

  assign out_valid = (cnt != EMPTY);
  assign full      = (cnt == FULL);
  assign out_data  = head_data;
  assign out_last  = head_last;
  assign pop       = out_valid && out_ready;

  always_comb begin
    cnt_next = cnt;
    unique case (cnt)
      EMPTY:   if (push) cnt_next = ONE;
      ONE: begin
        if (push && !pop)      cnt_next = FULL;
        else if (!push && pop) cnt_next = EMPTY;
      end
      FULL:    if (pop) cnt_next = ONE;
      default: cnt_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= EMPTY;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      cnt <= cnt_next;
      unique case (cnt)
        EMPTY: begin
          if (push) begin
            head_data <= push_data;
            head_last <= push_last;
          end
        end
        ONE: begin
          // Simultaneous push/pop replaces the head directly so order is kept.
          if (push && pop) begin
            head_data <= push_data;
            head_last <= push_last;
          end else if (push) begin
            tail_data <= push_data;
            tail_last <= push_last;
          end
        end
        FULL: begin
          if (pop) begin
            head_data <= tail_data;
            head_last <= tail_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

module demux_chip_1to2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_last,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_last,
  output logic             out_b_valid,
  input  logic             out_b_ready
`ifdef DEMUX_FRAME_COUNT_EN
  ,
  output logic [7:0]       frames_a,
  output logic [7:0]       frames_b
`endif
);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  state_t state, state_next;
  logic   dest;
  logic   full_a, full_b;
  logic   xfer;
  logic   push_a, push_b;

  always_comb begin
    unique case (state)
      LOCK_A:  dest = 1'b0;
      LOCK_B:  dest = 1'b1;
      default: dest = in_sel;
    endcase
  end

  // Gated by rst_n so nothing is offered as accepted while reset is held.
  assign in_ready = rst_n && !(dest ? full_b : full_a);
  assign xfer     = in_valid && in_ready;
  assign push_a   = xfer && !dest;
  assign push_b   = xfer && dest;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (xfer && !in_last) state_next = dest ? LOCK_B : LOCK_A;
      LOCK_A,
      LOCK_B:  if (xfer && in_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  demux_chip_1to2_buf #(.WIDTH(WIDTH)) u_buf_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_a),
    .push_data (in_data),
    .push_last (in_last),
    .full      (full_a),
    .out_data  (out_a_data),
    .out_last  (out_a_last),
    .out_valid (out_a_valid),
    .out_ready (out_a_ready)
  );

  demux_chip_1to2_buf #(.WIDTH(WIDTH)) u_buf_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_b),
    .push_data (in_data),
    .push_last (in_last),
    .full      (full_b),
    .out_data  (out_b_data),
    .out_last  (out_b_last),
    .out_valid (out_b_valid),
    .out_ready (out_b_ready)
  );

`ifdef DEMUX_FRAME_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_a <= '0;
      frames_b <= '0;
    end else begin
      if (push_a && in_last) frames_a <= frames_a + 8'd1;
      if (push_b && in_last) frames_b <= frames_b + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_chip_1to2.sv
// Directed bench for demux_chip_1to2: per-cycle vector table plus hand sequences
// for async reset mid-frame and (with DEMUX_FRAME_COUNT_EN) the frame counters.

module tb_demux_chip_1to2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_sel, in_last, in_valid, in_ready;
  logic [7:0] out_a_data, out_b_data;
  logic       out_a_last, out_a_valid, out_a_ready;
  logic       out_b_last, out_b_valid, out_b_ready;
`ifdef DEMUX_FRAME_COUNT_EN
  logic [7:0] frames_a, frames_b;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_chip_1to2 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_last     (in_last),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_a_data  (out_a_data),
    .out_a_last  (out_a_last),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_b_data  (out_b_data),
    .out_b_last  (out_b_last),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready)
`ifdef DEMUX_FRAME_COUNT_EN
    ,
    .frames_a    (frames_a),
    .frames_b    (frames_b)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic       sel, last, vld, ar, br;
    logic       rdy;
    logic       av; logic [7:0] ad; logic al;
    logic       bv; logic [7:0] bd; logic bl;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic sel, input logic last,
                       input logic vld, input logic ar, input logic br);
    in_data = d; in_sel = sel; in_last = last; in_valid = vld;
    out_a_ready = ar; out_b_ready = br;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;

    //           d     sel   last  vld   ar    br    rdy   av    ad     al    bv    bd     bl
    vecs[0]  = '{8'hA5,1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1, 1'b1,8'hA5,1'b1, 1'b0,8'h00,1'b0};
    vecs[1]  = '{8'h01,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b1, 1'b1,8'h01,1'b0, 1'b0,8'h00,1'b0};
    vecs[2]  = '{8'h02,1'b1,1'b0,1'b1,1'b1,1'b1, 1'b1, 1'b1,8'h02,1'b0, 1'b0,8'h00,1'b0};
    vecs[3]  = '{8'h03,1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1, 1'b1,8'h03,1'b1, 1'b0,8'h00,1'b0};
    vecs[4]  = '{8'h00,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0};
    vecs[5]  = '{8'h10,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b1, 1'b1,8'h10,1'b0, 1'b0,8'h00,1'b0};
    vecs[6]  = '{8'h11,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b1, 1'b1,8'h10,1'b0, 1'b0,8'h00,1'b0};
    vecs[7]  = '{8'h12,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0, 1'b1,8'h10,1'b0, 1'b0,8'h00,1'b0};
    vecs[8]  = '{8'h12,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0, 1'b1,8'h11,1'b0, 1'b0,8'h00,1'b0};
    vecs[9]  = '{8'h12,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b1, 1'b1,8'h12,1'b0, 1'b0,8'h00,1'b0};
    vecs[10] = '{8'h13,1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1, 1'b1,8'h13,1'b1, 1'b0,8'h00,1'b0};
    vecs[11] = '{8'h00,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0};
    vecs[12] = '{8'h20,1'b1,1'b0,1'b1,1'b1,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b1,8'h20,1'b0};
    vecs[13] = '{8'h21,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1, 1'b0,8'h00,1'b0, 1'b1,8'h20,1'b0};
    vecs[14] = '{8'h00,1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0, 1'b0,8'h00,1'b0, 1'b1,8'h20,1'b0};
    vecs[15] = '{8'h40,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1, 1'b1,8'h40,1'b0, 1'b1,8'h20,1'b0};
    vecs[16] = '{8'h41,1'b1,1'b0,1'b1,1'b1,1'b0, 1'b1, 1'b1,8'h41,1'b0, 1'b1,8'h20,1'b0};
    vecs[17] = '{8'h42,1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1, 1'b1,8'h42,1'b1, 1'b1,8'h20,1'b0};
    vecs[18] = '{8'h00,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b1,8'h21,1'b1};
    vecs[19] = '{8'h00,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b1, 1'b0,8'h00,1'b0, 1'b0,8'h00,1'b0};

    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_a_valid",  {31'd0, out_a_valid}, 32'd0);
    chk("rst_b_valid",  {31'd0, out_b_valid}, 32'd0);
    chk("rst_a_data",   {24'd0, out_a_data}, 32'd0);
    chk("rst_b_last",   {31'd0, out_b_last}, 32'd0);
    reset_pulse();

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].d, vecs[i].sel, vecs[i].last, vecs[i].vld, vecs[i].ar, vecs[i].br);
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_a_valid", i), {31'd0, out_a_valid}, {31'd0, vecs[i].av});
      chk($sformatf("v%0d_b_valid", i), {31'd0, out_b_valid}, {31'd0, vecs[i].bv});
      if (vecs[i].av) begin
        chk($sformatf("v%0d_a_data", i), {24'd0, out_a_data}, {24'd0, vecs[i].ad});
        chk($sformatf("v%0d_a_last", i), {31'd0, out_a_last}, {31'd0, vecs[i].al});
      end
      if (vecs[i].bv) begin
        chk($sformatf("v%0d_b_data", i), {24'd0, out_b_data}, {24'd0, vecs[i].bd});
        chk($sformatf("v%0d_b_last", i), {31'd0, out_b_last}, {31'd0, vecs[i].bl});
      end
    end

    // Reset asserted between edges while the second beat of an A frame is pending.
    drive(8'h50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("mid_a_valid_pre", {31'd0, out_a_valid}, 32'd1);
    drive(8'h51, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_valid",  {31'd0, out_a_valid}, 32'd0);
    chk("mid_rst_b_valid",  {31'd0, out_b_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_a_data",   {24'd0, out_a_data}, 32'd0);
    drive(8'h60, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("post_rst_b_valid", {31'd0, out_b_valid}, 32'd1);
    chk("post_rst_b_data",  {24'd0, out_b_data}, 32'h60);
    chk("post_rst_b_last",  {31'd0, out_b_last}, 32'd1);
    chk("post_rst_a_valid", {31'd0, out_a_valid}, 32'd0);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;

`ifdef DEMUX_FRAME_COUNT_EN
    reset_pulse();
    chk("cnt_rst_a", {24'd0, frames_a}, 32'd0);
    for (int k = 0; k < 256; k++) begin
      drive(k[7:0], 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 3; k++) begin
      drive(8'hB0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      @(posedge clk);
      #1;
    end
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("cnt_frames_a_wrap", {24'd0, frames_a}, 32'd0);
    chk("cnt_frames_b",      {24'd0, frames_b}, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
